// File: rtl/dyn_phase_resp_if.sv
// PLL dynamic phase-shift handshake bundle between a phase-shift controller (master)
// and the PLL-side responder (slave).
interface dyn_phase_resp_if #(
    parameter int unsigned NUM_CNT = 5,
    parameter int unsigned PHASE_W = 6
);
    logic                         PHASESTEP;
    logic                         PHASEUPDOWN;
    logic [3:0]                   PHASECOUNTERSELECT;
    logic                         ERR_CLR;
    logic                         PHASEDONE;
    logic [NUM_CNT*PHASE_W-1:0]   PHASE_OFS;
    logic [PHASE_W-1:0]           M_OFS;
    logic [15:0]                  STEP_CNT;
    logic                         ERR;

    modport master (
        output PHASESTEP, PHASEUPDOWN, PHASECOUNTERSELECT, ERR_CLR,
        input  PHASEDONE, PHASE_OFS, M_OFS, STEP_CNT, ERR
    );

    modport slave (
        input  PHASESTEP, PHASEUPDOWN, PHASECOUNTERSELECT, ERR_CLR,
        output PHASEDONE, PHASE_OFS, M_OFS, STEP_CNT, ERR
    );
endinterface

// File: rtl/dyn_phase_resp.sv
// PLL-side responder for the PHASESTEP/PHASEDONE phase-shift handshake.
// Define DYN_PHASE_RESP_SAT_EN to make the offset accumulators saturate instead of wrap.
module dyn_phase_resp #(
    parameter int unsigned NUM_CNT     = 5,
    parameter int unsigned PHASE_W     = 6,
    parameter int unsigned STEP_MIN_HI = 2,
    parameter int unsigned DONE_LAT    = 4
) (
    input  logic             CLK50M,
    input  logic             RESET,
    dyn_phase_resp_if.slave  ps_if
);
    localparam int unsigned HiW  = (STEP_MIN_HI > 1) ? $clog2(STEP_MIN_HI + 1) : 1;
    localparam int unsigned LatW = (DONE_LAT > 1) ? $clog2(DONE_LAT) : 1;
    localparam logic [PHASE_W-1:0] OfsOne = {{(PHASE_W-1){1'b0}}, 1'b1};
`ifdef DYN_PHASE_RESP_SAT_EN
    localparam logic [PHASE_W-1:0] OfsMax = {1'b0, {(PHASE_W-1){1'b1}}};
    localparam logic [PHASE_W-1:0] OfsMin = {1'b1, {(PHASE_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {StIdle, StArm, StBusy, StWaitRel} state_e;

    state_e             state_q, state_d;
    logic [HiW-1:0]     hi_cnt_q, hi_cnt_d;
    logic [LatW-1:0]    lat_cnt_q, lat_cnt_d;
    logic               done_q, done_d;
    logic [PHASE_W-1:0] ofs_q [NUM_CNT];
    logic [PHASE_W-1:0] ofs_d [NUM_CNT];
    logic [PHASE_W-1:0] m_ofs_q, m_ofs_d;
    logic [15:0]        step_cnt_q, step_cnt_d;
    logic               err_q, err_d;

    logic [HiW-1:0]     hi_nxt;
    logic               accept;
    logic               err_set;

    function automatic logic [PHASE_W-1:0] bump(input logic [PHASE_W-1:0] v, input logic up);
`ifdef DYN_PHASE_RESP_SAT_EN
        if (up && (v == OfsMax)) return v;
        if (!up && (v == OfsMin)) return v;
`endif
        return up ? (v + OfsOne) : (v - OfsOne);
    endfunction

    always_comb begin
        state_d    = state_q;
        hi_cnt_d   = hi_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        done_d     = done_q;
        ofs_d      = ofs_q;
        m_ofs_d    = m_ofs_q;
        step_cnt_d = step_cnt_q;
        err_set    = 1'b0;
        hi_nxt     = (state_q == StArm) ? (hi_cnt_q + HiW'(1)) : HiW'(1);
        accept     = 1'b0;

        unique case (state_q)
            StIdle: begin
                done_d   = 1'b1;
                hi_cnt_d = '0;
                if (ps_if.PHASESTEP) begin
                    if (hi_nxt == HiW'(STEP_MIN_HI)) accept = 1'b1;
                    else begin
                        hi_cnt_d = hi_nxt;
                        state_d  = StArm;
                    end
                end
            end
            StArm: begin
                if (!ps_if.PHASESTEP) begin
                    hi_cnt_d = '0;
                    state_d  = StIdle;
                end else if (hi_nxt == HiW'(STEP_MIN_HI)) begin
                    accept = 1'b1;
                end else begin
                    hi_cnt_d = hi_nxt;
                end
            end
            StBusy: begin
                if (lat_cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ps_if.PHASESTEP ? StWaitRel : StIdle;
                end else begin
                    lat_cnt_d = lat_cnt_q - LatW'(1);
                end
            end
            StWaitRel: begin
                done_d = 1'b1;
                if (!ps_if.PHASESTEP) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Direction and select are only looked at on the accept edge.
        if (accept) begin
            hi_cnt_d = '0;
            if (ps_if.PHASECOUNTERSELECT < 4'(2 + NUM_CNT)) begin
                done_d     = 1'b0;
                lat_cnt_d  = LatW'(DONE_LAT - 1);
                state_d    = StBusy;
                step_cnt_d = (step_cnt_q == 16'hFFFF) ? step_cnt_q : (step_cnt_q + 16'd1);
                if (ps_if.PHASECOUNTERSELECT == 4'd1) begin
                    m_ofs_d = bump(m_ofs_q, ps_if.PHASEUPDOWN);
                end else begin
                    for (int n = 0; n < NUM_CNT; n++) begin
                        if ((ps_if.PHASECOUNTERSELECT == 4'd0) ||
                            (ps_if.PHASECOUNTERSELECT == 4'(n + 2))) begin
                            ofs_d[n] = bump(ofs_q[n], ps_if.PHASEUPDOWN);
                        end
                    end
                end
            end else begin
                err_set = 1'b1;
                state_d = ps_if.PHASESTEP ? StWaitRel : StIdle;
            end
        end

        // A fresh invalid step beats a coincident clear.
        err_d = err_set ? 1'b1 : (ps_if.ERR_CLR ? 1'b0 : err_q);
    end

    always_ff @(posedge CLK50M) begin
        if (RESET) begin
            state_q    <= StIdle;
            hi_cnt_q   <= '0;
            lat_cnt_q  <= '0;
            done_q     <= 1'b1;
            for (int n = 0; n < NUM_CNT; n++) ofs_q[n] <= '0;
            m_ofs_q    <= '0;
            step_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_cnt_q   <= hi_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            done_q     <= done_d;
            ofs_q      <= ofs_d;
            m_ofs_q    <= m_ofs_d;
            step_cnt_q <= step_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_CNT; n++) ps_if.PHASE_OFS[n*PHASE_W +: PHASE_W] = ofs_q[n];
    end

    assign ps_if.PHASEDONE = done_q;
    assign ps_if.M_OFS     = m_ofs_q;
    assign ps_if.STEP_CNT  = step_cnt_q;
    assign ps_if.ERR       = err_q;
endmodule

// File: tb/tb_dyn_phase_resp.sv
// Directed bench for dyn_phase_resp: inputs driven and outputs sampled on the falling edge.
module tb_dyn_phase_resp;
    localparam int unsigned NUM_CNT = 5;
    localparam int unsigned PHASE_W = 6;
`ifdef DYN_PHASE_RESP_SAT_EN
    localparam logic [PHASE_W-1:0] M_EXP5 = 6'h1F;
`else
    localparam logic [PHASE_W-1:0] M_EXP5 = 6'h20;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [7:0] pat;
    logic       all_hi;
    int         lows;

    dyn_phase_resp_if #(.NUM_CNT(NUM_CNT), .PHASE_W(PHASE_W)) bus ();

    dyn_phase_resp #(
        .NUM_CNT(NUM_CNT), .PHASE_W(PHASE_W), .STEP_MIN_HI(2), .DONE_LAT(4)
    ) dut (
        .CLK50M(clk),
        .RESET (rst),
        .ps_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Hold PHASESTEP high for hi edges, then low long enough to finish BUSY.
    task automatic do_step(input logic [3:0] sel, input logic up, input int hi,
                           output logic done_hi);
        done_hi = 1'b1;
        bus.PHASESTEP = 1'b1;
        bus.PHASECOUNTERSELECT = sel;
        bus.PHASEUPDOWN = up;
        for (int i = 0; i < hi; i++) begin
            tick();
            done_hi &= bus.PHASEDONE;
        end
        bus.PHASESTEP = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            done_hi &= bus.PHASEDONE;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.PHASESTEP = 1'b0;
        bus.PHASEUPDOWN = 1'b0;
        bus.PHASECOUNTERSELECT = 4'd0;
        bus.ERR_CLR = 1'b0;
        tick();

        // 1: reset state, then single C0 up-step with select/dir only valid on the accept edge
        do_reset();
        check("rst_done", {63'd0, bus.PHASEDONE}, 64'd1);
        check("rst_ofs", {34'd0, bus.PHASE_OFS}, 64'd0);
        check("rst_m", {58'd0, bus.M_OFS}, 64'd0);
        check("rst_cnt", {48'd0, bus.STEP_CNT}, 64'd0);
        check("rst_err", {63'd0, bus.ERR}, 64'd0);
        bus.PHASESTEP = 1'b1;
        bus.PHASECOUNTERSELECT = 4'd5;
        bus.PHASEUPDOWN = 1'b0;
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat[i] = bus.PHASEDONE;
            if (i == 0) begin
                bus.PHASECOUNTERSELECT = 4'd2;
                bus.PHASEUPDOWN = 1'b1;
            end
            if (i == 1) begin
                bus.PHASECOUNTERSELECT = 4'd4;
                bus.PHASEUPDOWN = 1'b0;
            end
            if (i == 3) bus.PHASESTEP = 1'b0;
        end
        check("t1_done_window", {56'd0, pat}, 64'hE1);
        check("t1_ofs", {34'd0, bus.PHASE_OFS}, 64'd1);
        check("t1_m", {58'd0, bus.M_OFS}, 64'd0);
        check("t1_cnt", {48'd0, bus.STEP_CNT}, 64'd1);

        // 2: three down-steps on all C counters
        do_reset();
        for (int k = 0; k < 3; k++) do_step(4'd0, 1'b0, 2, all_hi);
        check("t2_ofs", {34'd0, bus.PHASE_OFS}, {34'd0, {5{6'h3D}}});
        check("t2_m", {58'd0, bus.M_OFS}, 64'd0);
        check("t2_cnt", {48'd0, bus.STEP_CNT}, 64'd3);

        // 3: runt pulse is ignored; a long hold gives exactly one step
        all_hi = 1'b1;
        bus.PHASESTEP = 1'b1;
        bus.PHASECOUNTERSELECT = 4'd1;
        bus.PHASEUPDOWN = 1'b1;
        tick();
        all_hi &= bus.PHASEDONE;
        bus.PHASESTEP = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            all_hi &= bus.PHASEDONE;
        end
        check("t3_runt_done", {63'd0, all_hi}, 64'd1);
        check("t3_runt_cnt", {48'd0, bus.STEP_CNT}, 64'd3);
        check("t3_runt_m", {58'd0, bus.M_OFS}, 64'd0);
        lows = 0;
        bus.PHASESTEP = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.PHASEDONE === 1'b0) lows++;
        end
        check("t3_hold_lows", 64'(lows), 64'd4);
        check("t3_hold_done", {63'd0, bus.PHASEDONE}, 64'd1);
        bus.PHASESTEP = 1'b0;
        tick();
        tick();
        check("t3_hold_cnt", {48'd0, bus.STEP_CNT}, 64'd4);
        check("t3_hold_m", {58'd0, bus.M_OFS}, 64'd1);

        // 4: invalid select sets ERR, clear, then clear coincident with another invalid step
        do_step(4'd9, 1'b1, 3, all_hi);
        check("t4_err", {63'd0, bus.ERR}, 64'd1);
        check("t4_done_hi", {63'd0, all_hi}, 64'd1);
        check("t4_cnt", {48'd0, bus.STEP_CNT}, 64'd4);
        check("t4_ofs", {34'd0, bus.PHASE_OFS}, {34'd0, {5{6'h3D}}});
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        check("t4_err_clr", {63'd0, bus.ERR}, 64'd0);
        bus.PHASESTEP = 1'b1;
        bus.PHASECOUNTERSELECT = 4'd9;
        tick();
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        check("t4_err_set_wins", {63'd0, bus.ERR}, 64'd1);
        bus.PHASESTEP = 1'b0;
        tick();
        tick();

        // 5: 32 up-steps on M overflow the 6-bit accumulator
        do_reset();
        for (int k = 0; k < 32; k++) do_step(4'd1, 1'b1, 2, all_hi);
        check("t5_m", {58'd0, bus.M_OFS}, {58'd0, M_EXP5});
        check("t5_cnt", {48'd0, bus.STEP_CNT}, 64'd32);
        check("t5_ofs", {34'd0, bus.PHASE_OFS}, 64'd0);

        // 6: reset during BUSY, then a normal step
        do_reset();
        bus.PHASESTEP = 1'b1;
        bus.PHASECOUNTERSELECT = 4'd2;
        bus.PHASEUPDOWN = 1'b1;
        tick();
        tick();
        check("t6_busy1", {63'd0, bus.PHASEDONE}, 64'd0);
        tick();
        check("t6_busy2", {63'd0, bus.PHASEDONE}, 64'd0);
        rst = 1'b1;
        bus.PHASESTEP = 1'b0;
        tick();
        check("t6_rst_done", {63'd0, bus.PHASEDONE}, 64'd1);
        check("t6_rst_ofs", {34'd0, bus.PHASE_OFS}, 64'd0);
        check("t6_rst_cnt", {48'd0, bus.STEP_CNT}, 64'd0);
        rst = 1'b0;
        tick();
        do_step(4'd3, 1'b1, 2, all_hi);
        check("t6_after_ofs", {34'd0, bus.PHASE_OFS}, 64'h40);
        check("t6_after_cnt", {48'd0, bus.STEP_CNT}, 64'd1);
        check("t6_after_done", {63'd0, bus.PHASEDONE}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
